// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-port round-robin front end for an APB master.
// Requesters hand over single read/write commands through valid/ready.
// The winning command is copied into hold registers, launched with a
// one-cycle TRANSFER strobe, and retired when the bus shows PENABLE&&PREADY.
// Completion data, slave error and a done pulse go back to the granted port.
// A sticky flag records any transfer that stalls for too long.
module apb_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,

    // requester 0
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,

    // requester 1
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,

    // APB master command side
    output logic        m_transfer,
    output logic        m_write,
    output logic        m_read,
    output logic [31:0] m_waddr,
    output logic [31:0] m_raddr,
    output logic [31:0] m_wdata,

    // APB bus observation
    input  logic        PENABLE,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic [31:0] PRDATA,

    // status
    output logic        busy,
    output logic        grant_id,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Stall threshold in the counter's own width; legal range is 1..255.
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    // ------------------------------------------------------------------
    // Requester ports gathered into indexable form
    // ------------------------------------------------------------------
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];

    assign req_valid    = {req1_valid, req0_valid};
    assign req_write    = {req1_write, req0_write};
    assign req_addr[0]  = req0_addr;
    assign req_addr[1]  = req1_addr;
    assign req_wdata[0] = req0_wdata;
    assign req_wdata[1] = req1_wdata;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        hold_write_q, hold_write_d;
    logic [31:0] hold_addr_q,  hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic        grant_id_q,   grant_id_d;
    logic        last_q,       last_d;
    logic [7:0]  cnt_q,        cnt_d;
    logic        timeout_q,    timeout_d;
    logic [1:0]  done_q,       done_d;
    logic [1:0]  err_q,        err_d;
    logic [31:0] rdata_q [2];
    logic [31:0] rdata_d [2];

    logic        winner;
    logic [1:0]  port_ready;
    logic        accept;
    logic        complete;
    logic [7:0]  cnt_inc;
    logic        m_transfer_c;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester always wins; on a tie the port that
    // did not own the last completed transfer wins. After reset last_q=1,
    // so port 0 takes the first tie.
    // ------------------------------------------------------------------
    assign winner   = (&req_valid) ? ~last_q : req_valid[1];
    assign accept   = |port_ready;
    assign complete = (state_q == ST_WAIT) && PENABLE && PREADY;

    // Per-port handshake and completion capture.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic port_hit;

            // Only the current winner sees ready, and only while idle.
            assign port_ready[gi] = (state_q == ST_IDLE) && req_valid[gi]
                                    && (winner == 1'(gi));

            // Completion belongs to whichever port owns the transfer.
            assign port_hit    = complete && (grant_id_q == 1'(gi));
            assign done_d[gi]  = port_hit;
            assign err_d[gi]   = port_hit ? PSLVERR : err_q[gi];
            assign rdata_d[gi] = port_hit ? PRDATA  : rdata_q[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic for the transfer FSM and the TRANSFER strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        m_transfer_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_transfer_c = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                if (complete) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Hold registers, grant owner and round-robin history update.
    always_comb begin
        hold_write_d = hold_write_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        grant_id_d   = grant_id_q;
        last_d       = last_q;
        if (accept) begin
            hold_write_d = req_write[winner];
            hold_addr_d  = req_addr[winner];
            hold_wdata_d = req_wdata[winner];
            grant_id_d   = winner;
        end
        if (complete) begin
            last_d = grant_id_q;
        end
    end

    // Stall counter: restarts as WAIT is entered, counts WAIT cycles that
    // do not complete (saturating), and latches the sticky flag the moment
    // the count hits the threshold. The FSM itself keeps waiting.
    assign cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == ST_ISSUE) begin
            cnt_d = 8'd0;
        end else if ((state_q == ST_WAIT) && !complete) begin
            cnt_d = cnt_inc;
            if (cnt_inc == TO_LIMIT) begin
                timeout_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // All state registers; a reset abandons any in-flight command.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= ST_IDLE;
            hold_write_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            grant_id_q   <= 1'b0;
            last_q       <= 1'b1;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            done_q       <= '0;
            err_q        <= '0;
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hold_write_q <= hold_write_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            grant_id_q   <= grant_id_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            err_q        <= err_d;
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy       = (state_q != ST_IDLE);
    assign m_transfer = m_transfer_c;
    assign m_write    = busy &&  hold_write_q;
    assign m_read     = busy && !hold_write_q;
    assign m_waddr    = hold_addr_q;
    assign m_raddr    = hold_addr_q;
    assign m_wdata    = hold_wdata_q;
    assign grant_id   = grant_id_q;
    assign timeout    = timeout_q;

    assign req0_ready = port_ready[0];
    assign req1_ready = port_ready[1];
    assign req0_done  = done_q[0];
    assign req1_done  = done_q[1];
    assign req0_err   = err_q[0];
    assign req1_err   = err_q[1];
    assign req0_rdata = rdata_q[0];
    assign req1_rdata = rdata_q[1];

endmodule
